fir_mac_lanes: RTL and testbench

Parametrised, multi-lane complex multiply-accumulate engine for the FIR datapath, replacing the single-lane MAC. It processes LANES independent complex samples per issue cycle. Each lane runs in one of three per-operation modes: cross (tap × sample + partial), auto (sample + partial) or accumulate (running tap × sample sum). All modes share one fixed latency, so cross and auto operations interleave freely without adder collisions.

---
 rtl/fir_pkg.sv | 40 ++++
 rtl/fir_cmult_pipe.sv | 53 +++++
 rtl/fir_mac_lanes.sv | 141 ++++++++++++++
 tb/tb_fir_mac_lanes.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the multi-lane complex FIR MAC.
package fir_pkg;

    localparam int FIR_DW     = 16;
    localparam int FIR_WIDE_W = 64;
    localparam int MAC_MODE_W = 2;

    typedef logic signed [FIR_WIDE_W-1:0] fir_wide_t;

    typedef struct packed {
        logic signed [FIR_DW-1:0] re;
        logic signed [FIR_DW-1:0] im;
    } fir_cplx_t;

    typedef enum logic [MAC_MODE_W-1:0] {
        MODE_CROSS  = 2'd0,
        MODE_AUTO   = 2'd1,
        MODE_ACC    = 2'd2,
        MODE_XCROSS = 2'd3
    } fir_mode_e;

    // Round-half-up, then arithmetic shift; shift 0 passes the value through.
    function automatic fir_wide_t fir_round_shift(input fir_wide_t v, input logic [7:0] sh);
        fir_wide_t bias;
        bias = '0;
        if (sh != 8'd0) bias = fir_wide_t'(1) <<< (sh - 8'd1);
        return (v + bias) >>> sh;
    endfunction

    function automatic fir_wide_t fir_saturate(input fir_wide_t v, input int unsigned dw);
        fir_wide_t hi;
        fir_wide_t lo;
        hi = (fir_wide_t'(1) <<< (dw - 1)) - fir_wide_t'(1);
        lo = -hi - fir_wide_t'(1);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fir_cmult_pipe.sv
// Full-precision complex multiplier with LAT registered stages (input register counts as the first).
module fir_cmult_pipe #(
    parameter int DW  = 16,
    parameter int LAT = 2
) (
    input  logic                clk,
    input  logic signed [DW-1:0] ar_i,
    input  logic signed [DW-1:0] ai_i,
    input  logic signed [DW-1:0] br_i,
    input  logic signed [DW-1:0] bi_i,
    output logic signed [2*DW:0] re_o,
    output logic signed [2*DW:0] im_o
);
    localparam int PW = 2 * DW + 1;

    logic signed [DW-1:0] ar_q, ai_q, br_q, bi_q;
    logic signed [PW-1:0] ar_x, ai_x, br_x, bi_x;
    logic signed [PW-1:0] re_c, im_c;

    // NOTE: pure datapath registers carry no reset; the valid pipe in the parent decides what is meaningful.
    always_ff @(posedge clk) begin
        ar_q <= ar_i;
        ai_q <= ai_i;
        br_q <= br_i;
        bi_q <= bi_i;
    end

    assign ar_x = PW'(ar_q);
    assign ai_x = PW'(ai_q);
    assign br_x = PW'(br_q);
    assign bi_x = PW'(bi_q);
    assign re_c = ar_x * br_x - ai_x * bi_x;
    assign im_c = ar_x * bi_x + ai_x * br_x;

    if (LAT == 1) begin : g_direct
        assign re_o = re_c;
        assign im_o = im_c;
    end else begin : g_pipe
        logic signed [PW-1:0] re_q [LAT-1];
        logic signed [PW-1:0] im_q [LAT-1];
        always_ff @(posedge clk) begin
            re_q[0] <= re_c;
            im_q[0] <= im_c;
            for (int i = 1; i < LAT - 1; i++) begin
                re_q[i] <= re_q[i-1];
                im_q[i] <= im_q[i-1];
            end
        end
        assign re_o = re_q[LAT-2];
        assign im_o = im_q[LAT-2];
    end

endmodule

// File: rtl/fir_mac_lanes.sv
// LANES-wide complex MAC: cross, auto and accumulate modes sharing one MULT_LAT+1 latency.
module fir_mac_lanes
    import fir_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int DW       = 16,
    parameter int MULT_LAT = 2,
    parameter int ACC_W    = 40,
    parameter int SHW      = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [MAC_MODE_W-1:0]   mode,
    input  logic [LANES*2*DW-1:0]   in_data,
    input  logic [LANES*2*DW-1:0]   tap,
    input  logic [SHW-1:0]          shift,
    input  logic [LANES*2*DW-1:0]   par_in,
    input  logic                    acc_clr,
    output logic                    out_valid,
    output logic [LANES*2*DW-1:0]   par_out
);
    localparam int CW = 2 * DW;
    localparam int PW = 2 * DW + 1;
    localparam int VW = LANES * CW;

    logic [MULT_LAT-1:0] vld_q;
    fir_mode_e           mode_q  [MULT_LAT];
    logic [SHW-1:0]      shift_q [MULT_LAT];
    logic [VW-1:0]       x_q     [MULT_LAT];

    logic                    out_valid_q;
    logic [VW-1:0]           par_out_q;
    logic [LANES-1:0][CW-1:0] lane_res;

    logic      vld_add;
    fir_mode_e mode_add;
    logic [7:0] sh_add;

    assign vld_add  = vld_q[MULT_LAT-1];
    assign mode_add = mode_q[MULT_LAT-1];
    assign sh_add   = 8'(shift_q[MULT_LAT-1]);

    // NOTE: every clocked block uses <= so all stages sample the pre-edge values of their neighbours.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_valid;
            for (int i = 1; i < MULT_LAT; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        mode_q[0]  <= fir_mode_e'(mode);
        shift_q[0] <= shift;
        x_q[0]     <= in_data;
        for (int i = 1; i < MULT_LAT; i++) begin
            mode_q[i]  <= mode_q[i-1];
            shift_q[i] <= shift_q[i-1];
            x_q[i]     <= x_q[i-1];
        end
    end

    function automatic logic signed [DW-1:0] lane_op(
        input fir_mode_e               m,
        input logic [7:0]              sh,
        input logic signed [PW-1:0]    prod,
        input logic signed [DW-1:0]    ax,
        input logic signed [DW-1:0]    p,
        input logic signed [ACC_W-1:0] acc_new
    );
        case (m)
            MODE_AUTO: return DW'(fir_saturate(fir_wide_t'(ax) + fir_wide_t'(p), DW));
            MODE_ACC:  return DW'(fir_saturate(fir_round_shift(fir_wide_t'(acc_new), sh), DW));
            default:   return DW'(fir_saturate(fir_round_shift(fir_wide_t'(prod), sh) + fir_wide_t'(p), DW));
        endcase
    endfunction

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam int B = l * CW;

        logic signed [DW-1:0]    x_re, x_im, t_re, t_im, ax_re, ax_im, p_re, p_im, r_re, r_im;
        logic signed [PW-1:0]    prod_re, prod_im;
        logic signed [ACC_W-1:0] acc_re_q, acc_im_q, acc_re_d, acc_im_d;

        assign x_re  = in_data[B+DW +: DW];
        assign x_im  = in_data[B    +: DW];
        assign t_re  = tap[B+DW +: DW];
        assign t_im  = tap[B    +: DW];
        assign ax_re = x_q[MULT_LAT-1][B+DW +: DW];
        assign ax_im = x_q[MULT_LAT-1][B    +: DW];
        assign p_re  = par_in[B+DW +: DW];
        assign p_im  = par_in[B    +: DW];

        fir_cmult_pipe #(.DW(DW), .LAT(MULT_LAT)) u_cmult (
            .clk  (clk),
            .ar_i (t_re),
            .ai_i (t_im),
            .br_i (x_re),
            .bi_i (x_im),
            .re_o (prod_re),
            .im_o (prod_im)
        );

        // A clear coinciding with an accumulate restarts the sum at this product.
        assign acc_re_d = (acc_clr ? '0 : acc_re_q) + ACC_W'(prod_re);
        assign acc_im_d = (acc_clr ? '0 : acc_im_q) + ACC_W'(prod_im);

        assign r_re = lane_op(mode_add, sh_add, prod_re, ax_re, p_re, acc_re_d);
        assign r_im = lane_op(mode_add, sh_add, prod_im, ax_im, p_im, acc_im_d);
        assign lane_res[l] = {r_re, r_im};

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                acc_re_q <= '0;
                acc_im_q <= '0;
            end else if (vld_add && mode_add == MODE_ACC) begin
                acc_re_q <= acc_re_d;
                acc_im_q <= acc_im_d;
            end else if (acc_clr) begin
                acc_re_q <= '0;
                acc_im_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            par_out_q   <= '0;
        end else begin
            out_valid_q <= vld_add;
            if (vld_add) par_out_q <= lane_res;
        end
    end

    assign out_valid = out_valid_q;
    assign par_out   = par_out_q;

endmodule

// File: tb/tb_fir_mac_lanes.sv
// Scoreboard bench for fir_mac_lanes: longint reference model, per-lane checks every cycle.
module tb_fir_mac_lanes;
    import fir_pkg::*;

    localparam int LANES    = 4;
    localparam int DW       = 16;
    localparam int MULT_LAT = 2;
    localparam int ACC_W    = 40;
    localparam int SHW      = 5;
    localparam int CW       = 2 * DW;
    localparam int VW       = LANES * CW;

    typedef struct {
        bit             vld;
        logic [1:0]     mode;
        logic [SHW-1:0] sh;
        logic [VW-1:0]  x;
        logic [VW-1:0]  tap;
        logic [VW-1:0]  par;
        bit             clr;
        bit             pin;
        logic [CW-1:0]  exp0;
    } op_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic [1:0]     mode = '0;
    logic [VW-1:0]  in_data = '0;
    logic [VW-1:0]  tap = '0;
    logic [SHW-1:0] shift = '0;
    logic [VW-1:0]  par_in = '0;
    logic           acc_clr = 1'b0;
    logic           out_valid;
    logic [VW-1:0]  par_out;

    fir_mac_lanes #(
        .LANES(LANES), .DW(DW), .MULT_LAT(MULT_LAT), .ACC_W(ACC_W), .SHW(SHW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .mode      (mode),
        .in_data   (in_data),
        .tap       (tap),
        .shift     (shift),
        .par_in    (par_in),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .par_out   (par_out)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_bad = 0;
    op_t           slot [MULT_LAT+2];
    logic [VW-1:0] exp_q [$];
    logic [VW-1:0] last_out = '0;
    longint        acc_m [LANES][2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] cp(input int re, input int im);
        fir_cplx_t z;
        z.re = 16'(re);
        z.im = 16'(im);
        return z;
    endfunction

    function automatic longint comp(input logic [VW-1:0] v, input int l, input int c);
        logic signed [DW-1:0] t;
        t = (c == 0) ? v[l*CW+DW +: DW] : v[l*CW +: DW];
        return longint'(t);
    endfunction

    function automatic longint m_sat(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic longint m_rnd(input longint v, input int sh);
        if (sh == 0) return v;
        return (v + (longint'(1) << (sh - 1))) >>> sh;
    endfunction

    function automatic longint m_wrap(input longint v);
        logic signed [ACC_W-1:0] w;
        w = v[ACC_W-1:0];
        return longint'(w);
    endfunction

    function automatic op_t idle_op();
        op_t o;
        o.vld = 0; o.mode = '0; o.sh = '0; o.x = '0; o.tap = '0; o.par = '0;
        o.clr = 0; o.pin = 0; o.exp0 = '0;
        return o;
    endfunction

    function automatic logic [CW-1:0] rnd_c(input bit big);
        int re, im;
        if (big) begin
            re = int'($urandom_range(0, 65535)) - 32768;
            im = int'($urandom_range(0, 65535)) - 32768;
        end else begin
            re = int'($urandom_range(0, 511)) - 256;
            im = int'($urandom_range(0, 511)) - 256;
        end
        return cp(re, im);
    endfunction

    // Lane 0 carries the directed values and a pinned expectation; other lanes get small random data.
    function automatic op_t mk(input int m, input int sh, input logic [CW-1:0] x0, input logic [CW-1:0] t0,
                               input logic [CW-1:0] p0, input bit clr, input logic [CW-1:0] e0);
        op_t o;
        o = idle_op();
        o.vld = 1; o.mode = 2'(m); o.sh = SHW'(sh); o.clr = clr; o.pin = 1; o.exp0 = e0;
        for (int l = 1; l < LANES; l++) begin
            o.x[l*CW +: CW]   = rnd_c(0);
            o.tap[l*CW +: CW] = rnd_c(0);
            o.par[l*CW +: CW] = rnd_c(0);
        end
        o.x[CW-1:0] = x0; o.tap[CW-1:0] = t0; o.par[CW-1:0] = p0;
        return o;
    endfunction

    function automatic op_t rnd_op();
        op_t o;
        bit  big;
        o = idle_op();
        o.vld  = ($urandom_range(0, 3) != 0);
        o.mode = 2'($urandom_range(0, 3));
        o.sh   = ($urandom_range(0, 3) == 0) ? SHW'($urandom_range(0, 31)) : SHW'($urandom_range(0, 16));
        o.clr  = ($urandom_range(0, 9) == 0);
        big    = ($urandom_range(0, 1) == 1);
        for (int l = 0; l < LANES; l++) begin
            o.x[l*CW +: CW]   = rnd_c(big);
            o.tap[l*CW +: CW] = rnd_c(big);
            o.par[l*CW +: CW] = rnd_c(big);
        end
        return o;
    endfunction

    // Reference model, applied in issue order (which is also add-stage order).
    task automatic model(input op_t op, output logic [VW-1:0] res);
        longint x[2], t[2], p[2], prod[2], r;
        res = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int c = 0; c < 2; c++) begin
                x[c] = comp(op.x, l, c);
                t[c] = comp(op.tap, l, c);
                p[c] = comp(op.par, l, c);
            end
            prod[0] = t[0] * x[0] - t[1] * x[1];
            prod[1] = t[0] * x[1] + t[1] * x[0];
            for (int c = 0; c < 2; c++) begin
                if (op.clr) acc_m[l][c] = 0;
                r = 0;
                if (op.vld) begin
                    case (op.mode)
                        2'd1: r = m_sat(x[c] + p[c]);
                        2'd2: begin
                            acc_m[l][c] = m_wrap(acc_m[l][c] + prod[c]);
                            r = m_sat(m_rnd(acc_m[l][c], int'(op.sh)));
                        end
                        default: r = m_sat(m_rnd(prod[c], int'(op.sh)) + p[c]);
                    endcase
                end
                res[l*CW + ((c == 0) ? DW : 0) +: DW] = r[DW-1:0];
            end
        end
        if (op.pin) res[CW-1:0] = op.exp0;
    endtask

    task automatic cycle(input op_t op, input bit rst);
        logic [VW-1:0] e;
        @(negedge clk);
        for (int k = MULT_LAT + 1; k > 0; k--) slot[k] = slot[k-1];
        slot[0] = op;
        check("out_valid", 64'(out_valid), 64'(slot[MULT_LAT+1].vld));
        if (slot[MULT_LAT+1].vld) begin
            if (exp_q.size() == 0) check("scoreboard_empty", 64'(exp_q.size()), 64'd1);
            else last_out = exp_q.pop_front();
        end
        for (int l = 0; l < LANES; l++)
            check($sformatf("par_out_lane%0d", l), 64'(par_out[l*CW +: CW]), 64'(last_out[l*CW +: CW]));
        if (rst) begin
            rst_n = 1'b0;
            for (int k = 0; k < MULT_LAT + 2; k++) slot[k] = idle_op();
            exp_q.delete();
            for (int l = 0; l < LANES; l++) begin
                acc_m[l][0] = 0;
                acc_m[l][1] = 0;
            end
            last_out = '0;
        end else begin
            rst_n = 1'b1;
            model(op, e);
            if (op.vld) exp_q.push_back(e);
        end
        in_valid = slot[0].vld;
        mode     = slot[0].mode;
        shift    = slot[0].sh;
        in_data  = slot[0].x;
        tap      = slot[0].tap;
        par_in   = slot[MULT_LAT].par;
        acc_clr  = slot[MULT_LAT].clr;
    endtask

    initial begin
        op_t a;
        for (int k = 0; k < MULT_LAT + 2; k++) slot[k] = idle_op();
        for (int l = 0; l < LANES; l++) begin
            acc_m[l][0] = 0;
            acc_m[l][1] = 0;
        end
        repeat (3) @(posedge clk);
        cycle(idle_op(), 1);
        cycle(idle_op(), 1);

        cycle(mk(0, 0, cp(3, 2), cp(1, 1), cp(10, 0), 0, cp(11, 5)), 0);
        repeat (4) cycle(idle_op(), 0);

        cycle(mk(1, 0, cp(5, -5), cp(0, 0), cp(1, 1), 0, cp(6, -4)), 0);
        cycle(mk(0, 0, cp(3, 2), cp(1, 1), cp(10, 0), 0, cp(11, 5)), 0);
        repeat (4) cycle(idle_op(), 0);

        cycle(mk(0, 0,  cp(32767, 0), cp(32767, 0), cp(0, 0), 0, cp(32767, 0)), 0);
        cycle(mk(0, 15, cp(32767, 0), cp(32767, 0), cp(0, 0), 0, cp(32766, 0)), 0);
        repeat (4) cycle(idle_op(), 0);

        for (int i = 1; i <= 4; i++)
            cycle(mk(2, 0, cp(3, 1), cp(2, 0), cp(0, 0), 0, cp(6 * i, 2 * i)), 0);
        cycle(mk(2, 0, cp(3, 1), cp(2, 0), cp(0, 0), 1, cp(6, 2)), 0);
        repeat (4) cycle(idle_op(), 0);

        a = mk(2, 0, cp(3, 1), cp(2, 0), cp(0, 0), 0, cp(12, 4));
        cycle(a, 0);
        a.exp0 = cp(18, 6);
        cycle(a, 0);
        cycle(idle_op(), 1);
        cycle(mk(2, 0, cp(3, 1), cp(2, 0), cp(0, 0), 0, cp(6, 2)), 0);
        repeat (4) cycle(idle_op(), 0);

        repeat (400) cycle(rnd_op(), 0);
        repeat (MULT_LAT + 3) cycle(idle_op(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
